// File: rtl/fmas_retire_if.sv
// fmas_retire_if -- handshake bundle between the issuer/fmas unit, the
// retire block and the result consumer.
//   req_valid / req_ready / fmas_req : issue handshake toward the fmas unit
//   fmas_rslt / fmas_flag            : fmas unit outputs, sampled at capture
//   out_valid / out_ready            : result FIFO head handshake
//   out_rslt / out_flag              : result FIFO head contents
// slave  : the retire block
// master : the issuer / fmas unit / consumer side
interface fmas_retire_if;
    logic        req_valid;
    logic        req_ready;
    logic        fmas_req;
    logic [31:0] fmas_rslt;
    logic [4:0]  fmas_flag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rslt;
    logic [4:0]  out_flag;

    modport slave (
        input  req_valid,
        output req_ready,
        output fmas_req,
        input  fmas_rslt,
        input  fmas_flag,
        output out_valid,
        input  out_ready,
        output out_rslt,
        output out_flag
    );

    modport master (
        output req_valid,
        input  req_ready,
        input  fmas_req,
        output fmas_rslt,
        output fmas_flag,
        input  out_valid,
        output out_ready,
        input  out_rslt,
        input  out_flag
    );
endinterface

// File: rtl/fmas_retire.sv
// fmas_retire -- tracks operations in flight through a fixed-latency fmas
// unit, captures each result/flag pair into a small FIFO and accrues sticky
// exception flags.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : issue handshake, fmas outputs, FIFO head handshake
//   fflags            : sticky accrued exception flags {NV,DZ,OF,UF,NX}
//   fflags_wr/_wdata  : software write of fflags (captured flags still OR in)
//   fflags_clr        : clear fflags (captured flags still OR in)
//   count             : FIFO occupancy
//   busy              : any operation in flight or FIFO non-empty
module fmas_retire #(
    parameter int DEPTH = 4,
    parameter int LAT   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    fmas_retire_if.slave            bus,
    output logic [4:0]              fflags,
    input  logic                    fflags_wr,
    input  logic [4:0]              fflags_wdata,
    input  logic                    fflags_clr,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(DEPTH + LAT + 1) + 1;

    function automatic logic [SW-1:0] pop_valid(input logic [LAT-1:0] v);
        logic [SW-1:0] n;
        n = '0;
        for (int i = 0; i < LAT; i++) begin
            n = n + SW'(v[i]);
        end
        return n;
    endfunction

    logic [LAT-1:0] vld_p;
    logic [SW-1:0]  inflight;
    logic [SW-1:0]  used;
    logic           capture;
    logic           pop;
    logic [4:0]     cap_flags;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [31:0]    mem_rslt [DEPTH];
    logic [4:0]     mem_flag [DEPTH];

    // Credit check uses registered state only: every in-flight op already
    // owns a FIFO slot, so a capture can never find the FIFO full.
    assign inflight      = pop_valid(vld_p);
    assign used          = SW'(count) + inflight;
    assign bus.req_ready = !reset && (used < SW'(DEPTH));
    assign bus.fmas_req  = bus.req_valid & bus.req_ready;

    assign capture   = vld_p[LAT-1];
    assign cap_flags = capture ? bus.fmas_flag : 5'd0;

    // Head is read straight from storage; masking with out_valid keeps the
    // outputs at zero while empty or in reset without a write bypass.
    assign bus.out_valid = !reset && (count != '0);
    assign pop           = bus.out_valid & bus.out_ready;
    assign bus.out_rslt  = bus.out_valid ? mem_rslt[rd_ptr] : 32'd0;
    assign bus.out_flag  = bus.out_valid ? mem_flag[rd_ptr] : 5'd0;
    assign busy          = !reset && ((inflight != '0) || (count != '0));

    // stage p0..pLAT-1: valid shift register mirroring the fmas pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            fflags <= '0;
        end else begin
            vld_p[0] <= bus.fmas_req;
            for (int i = 1; i < LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end

            if (capture) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);

            case ({capture, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (fflags_wr)       fflags <= fflags_wdata | cap_flags;
            else if (fflags_clr) fflags <= cap_flags;
            else                 fflags <= fflags | cap_flags;
        end
    end

    // capture stage: last valid stage writes the FIFO tail
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_rslt[wr_ptr] <= bus.fmas_rslt;
            mem_flag[wr_ptr] <= bus.fmas_flag;
        end
    end
endmodule

// File: tb/tb_fmas_retire.sv
// tb_fmas_retire -- self-checking bench for fmas_retire. A behavioural fmas
// stand-in delays the result chosen at issue by LAT cycles; a scoreboard
// queue receives each accepted op and is checked against every pop.
module tb_fmas_retire;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [4:0]             fflags;
    logic                   fflags_wr;
    logic [4:0]             fflags_wdata;
    logic                   fflags_clr;
    logic [$clog2(DEPTH):0] count;
    logic                   busy;

    logic        req_valid;
    logic        out_ready;
    logic [31:0] op_rslt;
    logic [4:0]  op_flag;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;

    logic [36:0] exp_q [$];
    logic [36:0] pipe [LAT];

    fmas_retire_if bus();

    assign bus.req_valid = req_valid;
    assign bus.out_ready = out_ready;
    assign bus.fmas_rslt = pipe[LAT-1][31:0];
    assign bus.fmas_flag = pipe[LAT-1][36:32];

    fmas_retire #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .fflags       (fflags),
        .fflags_wr    (fflags_wr),
        .fflags_wdata (fflags_wdata),
        .fflags_clr   (fflags_clr),
        .count        (count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // fmas stand-in plus scoreboard push
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
            exp_q.delete();
        end else begin
            pipe[0] <= bus.fmas_req ? {op_flag, op_rslt} : 37'd0;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            if (bus.fmas_req) exp_q.push_back({op_flag, op_rslt});
        end
    end

    // scoreboard pop/compare
    always @(negedge clk) begin
        logic [36:0] e;
        if (bus.out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected actual=%h required=none t=%0t", bus.out_rslt, $time);
            end else begin
                e = exp_q.pop_front();
                chk("pop_rslt", bus.out_rslt, e[31:0]);
                chk("pop_flag", {27'd0, bus.out_flag}, {27'd0, e[36:32]});
                pops++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] rslt;
        logic [4:0]  flag;
    } vec_t;

    vec_t vecs [6];

    // single op with out_ready=1: visible exactly in cycle 3
    task automatic run_vec(input int idx);
        op_rslt   = vecs[idx].rslt;
        op_flag   = vecs[idx].flag;
        out_ready = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_req_ready", idx), {31'd0, bus.req_ready}, 32'd1);
        chk($sformatf("v%0d_fmas_req", idx), {31'd0, bus.fmas_req}, 32'd1);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_c1_out_valid", idx), {31'd0, bus.out_valid}, 32'd0);
        chk($sformatf("v%0d_c1_busy", idx), {31'd0, busy}, 32'd1);
        step();
        @(negedge clk);
        chk($sformatf("v%0d_c2_out_valid", idx), {31'd0, bus.out_valid}, 32'd0);
        step();
        @(negedge clk);
        chk($sformatf("v%0d_c3_out_valid", idx), {31'd0, bus.out_valid}, 32'd1);
        chk($sformatf("v%0d_out_rslt", idx), bus.out_rslt, vecs[idx].rslt);
        chk($sformatf("v%0d_out_flag", idx), {27'd0, bus.out_flag}, {27'd0, vecs[idx].flag});
        chk($sformatf("v%0d_fflags", idx), {27'd0, fflags}, {27'd0, vecs[idx].flag});
        step();
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_fflags_clr", idx), {27'd0, fflags}, 32'd0);
        chk($sformatf("v%0d_busy_idle", idx), {31'd0, busy}, 32'd0);
        step();
    endtask

    initial begin
        int accepted;
        int pops_before;
        logic [4:0] bpf [4];

        // operands noted as x*y+z
        vecs[0] = '{32'h40200000, 5'h00};  // 1.0*2.0+0.5
        vecs[1] = '{32'h7fc00001, 5'h10};  // sNaN*1.0+0
        vecs[2] = '{32'h7f800000, 5'h05};  // overflow
        vecs[3] = '{32'h00000000, 5'h03};  // underflow to zero
        vecs[4] = '{32'h3eaaaaab, 5'h01};  // inexact
        vecs[5] = '{32'hc0400000, 5'h00};  // -1.0*2.0-1.0
        bpf = '{5'h01, 5'h02, 5'h04, 5'h10};

        reset        = 1'b1;
        req_valid    = 1'b1;
        out_ready    = 1'b1;
        fflags_wr    = 1'b1;
        fflags_wdata = 5'h1f;
        fflags_clr   = 1'b0;
        op_rslt      = 32'h0;
        op_flag      = 5'h0;
        step();
        step();
        @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_fmas_req", {31'd0, bus.fmas_req}, 32'd0);
        chk("rst_out_rslt", bus.out_rslt, 32'd0);
        chk("rst_out_flag", {27'd0, bus.out_flag}, 32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_fflags", {27'd0, fflags}, 32'd0);
        step();
        reset     = 1'b0;
        req_valid = 1'b0;
        fflags_wr = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        step();

        for (int i = 0; i < 6; i++) run_vec(i);

        // software write merges with a same-cycle capture
        op_rslt = 32'h11111111; op_flag = 5'h04; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        fflags_wr = 1'b1; fflags_wdata = 5'h01;
        step();
        fflags_wr = 1'b0;
        @(negedge clk);
        chk("wr_with_capture", {27'd0, fflags}, 32'h05);
        step();
        op_rslt = 32'h22222222; op_flag = 5'h10; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        @(negedge clk);
        chk("clr_with_capture", {27'd0, fflags}, 32'h10);
        step();
        fflags_wr = 1'b1; fflags_wdata = 5'h0a;
        step();
        fflags_wr = 1'b0;
        @(negedge clk);
        chk("wr_no_capture", {27'd0, fflags}, 32'h0a);
        step();
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;

        // backpressure: exactly DEPTH accepted, flags accrue before any pop
        out_ready = 1'b0;
        req_valid = 1'b1;
        accepted  = 0;
        for (int i = 0; i < 8; i++) begin
            op_rslt = 32'hA0000000 + 32'(i);
            op_flag = (i < 4) ? bpf[i] : 5'h1f;
            @(negedge clk);
            chk($sformatf("bp_req_ready_c%0d", i), {31'd0, bus.req_ready}, (i < 4) ? 32'd1 : 32'd0);
            if (bus.fmas_req) accepted++;
            step();
        end
        req_valid = 1'b0;
        chk("bp_accepted", 32'(accepted), 32'd4);
        step();
        @(negedge clk);
        chk("bp_count_full", {28'd0, count}, 32'd4);
        chk("bp_fflags_accrued", {27'd0, fflags}, 32'h17);
        chk("bp_req_ready_full", {31'd0, bus.req_ready}, 32'd0);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_pop_cycle", {31'd0, bus.req_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("bp_ready_after_pop", {31'd0, bus.req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) step();
        @(negedge clk);
        chk("bp_count_drained", {28'd0, count}, 32'd0);
        chk("bp_queue_empty", exp_q.size(), 32'd0);
        step();

        // back-to-back issue: push and pop together at count==1
        pops_before = pops;
        out_ready   = 1'b1;
        req_valid   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            op_rslt = 32'hB0000000 + 32'(i);
            op_flag = 5'h00;
            if (i == 6) req_valid = 1'b0;
            @(negedge clk);
            if (i >= 3 && i <= 8) chk($sformatf("b2b_count_c%0d", i), {28'd0, count}, 32'd1);
            if (i == 9) chk("b2b_count_end", {28'd0, count}, 32'd0);
            if (i < 6) chk($sformatf("b2b_ready_c%0d", i), {31'd0, bus.req_ready}, 32'd1);
            step();
        end
        chk("b2b_pops", 32'(pops - pops_before), 32'd6);

        // reset with two ops in flight discards them
        op_flag = 5'h1f; op_rslt = 32'hC0000000; req_valid = 1'b1;
        step();
        op_rslt = 32'hC0000001;
        @(negedge clk);
        chk("rst_mid_busy", {31'd0, busy}, 32'd1);
        step();
        req_valid = 1'b0;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rst_mid_out_valid_c%0d", i), {31'd0, bus.out_valid}, 32'd0);
            step();
        end
        @(negedge clk);
        chk("rst_mid_count", {28'd0, count}, 32'd0);
        chk("rst_mid_fflags", {27'd0, fflags}, 32'd0);
        chk("rst_mid_busy_end", {31'd0, busy}, 32'd0);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
